// File: rtl/ddr3_pkg.sv
// Shared definitions for the DDR3 user-command arbitration logic:
// MIG command encodings, arbiter state encodings and the address width.
package ddr3_pkg;

  localparam int DDR3_ADDR_W = 26;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    TURN  = 2'd3
  } arb_state_e;

  // Map a direction flag (1 = read) onto the grant state serving it
  function automatic arb_state_e grant_state(input logic to_read);
    return to_read ? READ : WRITE;
  endfunction

endpackage

// File: rtl/ddr3_cmd_arbiter.sv
// Shares the single MIG user command port between the write-side and the
// read-side controllers. Writes win ties, a per-grant quota bounds how long
// one side can starve the other, and an idle gap is inserted whenever the
// bus direction changes.
module ddr3_cmd_arbiter
  import ddr3_pkg::*;
#(
  parameter int MAX_BURST = 64,
  parameter int TURN_GAP  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_app_en,
  input  logic [DDR3_ADDR_W-1:0] ddr3_wr_addr,
  output logic                   wr_app_rdy,
  input  logic                   rd_app_en,
  input  logic [DDR3_ADDR_W-1:0] ddr3_rd_addr,
  output logic                   rd_app_rdy,
  output logic                   app_en,
  output logic [2:0]             app_cmd,
  output logic [DDR3_ADDR_W-1:0] app_addr,
  input  logic                   app_rdy,
  input  logic                   app_wdf_rdy,
  output logic                   app_wdf_wren,
  output logic                   app_wdf_end,
  output logic [15:0]            grant_switch_cnt
);

  localparam int Q_W = $clog2(MAX_BURST + 1);
  localparam int G_W = (TURN_GAP > 1) ? $clog2(TURN_GAP) : 1;
  localparam logic [Q_W-1:0] QUOTA_MAX = Q_W'(MAX_BURST);
  localparam logic [G_W-1:0] GAP_LOAD  = (TURN_GAP > 0) ? G_W'(TURN_GAP - 1) : '0;

  arb_state_e             state_q, state_d;
  logic                   last_read_q;
  logic                   target_read_q, target_read_d;
  logic [Q_W-1:0]         quota_q, quota_inc;
  logic [G_W-1:0]         gap_q;
  logic [15:0]            switch_q;
  logic [2:0]             hold_cmd_q;
  logic [DDR3_ADDR_W-1:0] hold_addr_q;

  logic write_accept, read_accept, accept;
  logic exhausted, quota_clr;
  logic go, go_read;
  logic enter_grant, enter_read;

  assign write_accept = (state_q == WRITE) && wr_app_en && app_rdy && app_wdf_rdy;
  assign read_accept  = (state_q == READ) && rd_app_en && app_rdy;
  assign accept       = write_accept || read_accept;

  assign quota_inc = accept ? quota_q + Q_W'(1) : quota_q;
  assign exhausted = (quota_inc == QUOTA_MAX);

  assign enter_grant = ((state_d == WRITE) || (state_d == READ)) && (state_d != state_q);
  assign enter_read  = (state_d == READ);

  assign wr_app_rdy       = write_accept;
  assign rd_app_rdy       = read_accept;
  assign app_wdf_end      = app_wdf_wren;
  assign grant_switch_cnt = switch_q;

  // Next-state selection: decide who owns the port next and whether a turnaround gap is needed
  always_comb begin
    state_d       = state_q;
    target_read_d = target_read_q;
    quota_clr     = 1'b0;
    go            = 1'b0;
    go_read       = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr_app_en) begin
          go      = 1'b1;
          go_read = 1'b0;
        end else if (rd_app_en) begin
          go      = 1'b1;
          go_read = 1'b1;
        end
      end
      WRITE: begin
        if ((exhausted || !wr_app_en) && rd_app_en) begin
          go      = 1'b1;
          go_read = 1'b1;
        end else if (!wr_app_en) begin
          state_d = IDLE;
        end else if (exhausted) begin
          quota_clr = 1'b1;
        end
      end
      READ: begin
        if ((exhausted || !rd_app_en) && wr_app_en) begin
          go      = 1'b1;
          go_read = 1'b0;
        end else if (!rd_app_en) begin
          state_d = IDLE;
        end else if (exhausted) begin
          quota_clr = 1'b1;
        end
      end
      TURN: begin
        if (gap_q == '0) begin
          state_d = grant_state(target_read_q);
        end
      end
      default: state_d = IDLE;
    endcase

    if (go) begin
      if ((go_read != last_read_q) && (TURN_GAP != 0)) begin
        state_d       = TURN;
        target_read_d = go_read;
      end else begin
        state_d = grant_state(go_read);
      end
    end
  end

  // Command port drive: only the granted side reaches the MIG, IDLE/TURN hold the last command and address
  always_comb begin
    app_en       = 1'b0;
    app_cmd      = hold_cmd_q;
    app_addr     = hold_addr_q;
    app_wdf_wren = 1'b0;

    case (state_q)
      WRITE: begin
        app_en       = wr_app_en && app_wdf_rdy;
        app_cmd      = CMD_WRITE;
        app_addr     = ddr3_wr_addr;
        app_wdf_wren = write_accept;
      end
      READ: begin
        app_en   = rd_app_en;
        app_cmd  = CMD_READ;
        app_addr = ddr3_rd_addr;
      end
      default: ;
    endcase
  end

  // State register plus quota, turnaround gap, direction history and switch counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_read_q   <= 1'b0;
      target_read_q <= 1'b0;
      quota_q       <= '0;
      gap_q         <= '0;
      switch_q      <= '0;
      hold_cmd_q    <= CMD_READ;
      hold_addr_q   <= '0;
    end else begin
      state_q       <= state_d;
      target_read_q <= target_read_d;

      if (enter_grant || quota_clr) begin
        quota_q <= '0;
      end else begin
        quota_q <= quota_inc;
      end

      if ((state_d == TURN) && (state_q != TURN)) begin
        gap_q <= GAP_LOAD;
      end else if ((state_q == TURN) && (gap_q != '0)) begin
        gap_q <= gap_q - G_W'(1);
      end

      if (enter_grant) begin
        last_read_q <= enter_read;
        if (enter_read != last_read_q) begin
          switch_q <= switch_q + 16'd1;
        end
      end

      if ((state_q == WRITE) || (state_q == READ)) begin
        hold_cmd_q  <= app_cmd;
        hold_addr_q <= app_addr;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Randomized scoreboard bench for ddr3_cmd_arbiter. A port-ownership model
// predicts every accepted command with its cycle stamp; a monitor checks each
// command the MIG actually takes against that prediction.
module tb_ddr3_cmd_arbiter;

  localparam int MB  = 4;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_app_en = 1'b0;
  logic [25:0] ddr3_wr_addr = '0;
  logic        wr_app_rdy;
  logic        rd_app_en = 1'b0;
  logic [25:0] ddr3_rd_addr = '0;
  logic        rd_app_rdy;
  logic        app_en;
  logic [2:0]  app_cmd;
  logic [25:0] app_addr;
  logic        app_rdy = 1'b0;
  logic        app_wdf_rdy = 1'b0;
  logic        app_wdf_wren;
  logic        app_wdf_end;
  logic [15:0] grant_switch_cnt;

  ddr3_cmd_arbiter #(.MAX_BURST(MB), .TURN_GAP(GAP)) dut (
    .clk              (clk),
    .reset            (reset),
    .wr_app_en        (wr_app_en),
    .ddr3_wr_addr     (ddr3_wr_addr),
    .wr_app_rdy       (wr_app_rdy),
    .rd_app_en        (rd_app_en),
    .ddr3_rd_addr     (ddr3_rd_addr),
    .rd_app_rdy       (rd_app_rdy),
    .app_en           (app_en),
    .app_cmd          (app_cmd),
    .app_addr         (app_addr),
    .app_rdy          (app_rdy),
    .app_wdf_rdy      (app_wdf_rdy),
    .app_wdf_wren     (app_wdf_wren),
    .app_wdf_end      (app_wdf_end),
    .grant_switch_cnt (grant_switch_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          is_read;
    logic [25:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rd_seen = 0;

  // Requester state: a raised request is held with its address until accepted
  bit          wr_pend = 0;
  bit          rd_pend = 0;
  logic [25:0] wr_addr_r = '0;
  logic [25:0] rd_addr_r = '0;
  int          rd_left = 1000000;

  // Reference model: who owns the port, how many silent cycles remain before
  // the owner may issue, commands used this grant, last served direction
  int m_owner = 0;     // 0 none, 1 write side, 2 read side
  int m_silence = 0;
  int m_used = 0;
  int m_last = 1;
  int m_switches = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, actual, expected);
    end
  endtask

  task automatic modelReset();
    m_owner = 0;
    m_silence = 0;
    m_used = 0;
    m_last = 1;
    m_switches = 0;
  endtask

  task automatic handOver(input int side);
    m_owner = side;
    m_used = 0;
    if (side != m_last && GAP > 0) begin
      m_silence = GAP;
    end else begin
      m_silence = 0;
      if (side != m_last) m_switches = (m_switches + 1) % 65536;
      m_last = side;
    end
  endtask

  task automatic modelStep();
    bit wreq, rreq, acc, mine, other, full;
    wreq = wr_pend;
    rreq = rd_pend;
    if (m_owner != 0 && m_silence == 0) begin
      acc = (m_owner == 1) ? (wreq && app_rdy && app_wdf_rdy) : (rreq && app_rdy);
      if (acc) begin
        exp_q.push_back('{cyc: cyc, is_read: (m_owner == 2), addr: (m_owner == 2) ? rd_addr_r : wr_addr_r});
        if (m_owner == 1) wr_pend = 0; else rd_pend = 0;
        m_used++;
      end
      mine  = (m_owner == 1) ? wreq : rreq;
      other = (m_owner == 1) ? rreq : wreq;
      full  = (m_used == MB);
      if ((full || !mine) && other) handOver(3 - m_owner);
      else if (!mine) m_owner = 0;
      else if (full) m_used = 0;
    end else if (m_owner == 0) begin
      if (wreq) handOver(1);
      else if (rreq) handOver(2);
    end else begin
      m_silence--;
      if (m_silence == 0) begin
        m_last = m_owner;
        m_used = 0;
        m_switches = (m_switches + 1) % 65536;
      end
    end
  endtask

  task automatic applyStimulus(input int wp, input int rp, input int rdyp, input int wdfp);
    if (!wr_pend && $urandom_range(99) < wp) begin
      wr_pend = 1;
      wr_addr_r = 26'($urandom);
    end
    if (!rd_pend && rd_left > 0 && $urandom_range(99) < rp) begin
      rd_pend = 1;
      rd_addr_r = 26'($urandom);
      rd_left--;
    end
    wr_app_en    = wr_pend;
    ddr3_wr_addr = wr_addr_r;
    rd_app_en    = rd_pend;
    ddr3_rd_addr = rd_addr_r;
    app_rdy      = ($urandom_range(99) < rdyp);
    app_wdf_rdy  = ($urandom_range(99) < wdfp);
  endtask

  task automatic runCycle(input bit rst, input int wp, input int rp, input int rdyp, input int wdfp);
    @(posedge clk);
    #1;
    reset = rst;
    checkOutput("grant_switch_cnt", 32'(grant_switch_cnt), 32'(m_switches));
    applyStimulus(wp, rp, rdyp, wdfp);
    modelStep();
    if (rst) modelReset();
  endtask

  task automatic checkResetOutputs();
    @(negedge clk);
    checkOutput("rst_app_en", 32'(app_en), 0);
    checkOutput("rst_app_wdf_wren", 32'(app_wdf_wren), 0);
    checkOutput("rst_app_wdf_end", 32'(app_wdf_end), 0);
    checkOutput("rst_wr_app_rdy", 32'(wr_app_rdy), 0);
    checkOutput("rst_rd_app_rdy", 32'(rd_app_rdy), 0);
    checkOutput("rst_app_cmd", 32'(app_cmd), 32'h1);
    checkOutput("rst_app_addr", 32'(app_addr), 0);
    checkOutput("rst_grant_switch_cnt", 32'(grant_switch_cnt), 0);
  endtask

  // Monitor: every command the MIG takes must match the oldest prediction, in the predicted cycle
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checkOutput("missed_accept", 32'(cyc), 32'(e.cyc));
    end
    checkOutput("wdf_end_eq_wren", 32'(app_wdf_end), 32'(app_wdf_wren));
    if (app_en && app_rdy) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_accept", 32'(app_cmd), 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        checkOutput("accept_cycle", 32'(cyc), 32'(e.cyc));
        checkOutput("accept_cmd", 32'(app_cmd), e.is_read ? 32'h1 : 32'h0);
        checkOutput("accept_addr", 32'(app_addr), 32'(e.addr));
        checkOutput("wr_app_rdy", 32'(wr_app_rdy), e.is_read ? 0 : 1);
        checkOutput("rd_app_rdy", 32'(rd_app_rdy), e.is_read ? 1 : 0);
        checkOutput("app_wdf_wren", 32'(app_wdf_wren), e.is_read ? 0 : 1);
        if (rd_app_rdy) rd_seen++;
      end
    end else begin
      checkOutput("idle_strobes", {29'd0, wr_app_rdy, rd_app_rdy, app_wdf_wren}, 0);
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int rd_base;
    bit reached;

    // Power-on reset
    for (int i = 0; i < 3; i++) runCycle(1, 0, 0, 100, 100);
    checkResetOutputs();

    // Read-only burst of ten commands after a write-biased reset
    rd_left = 10;
    rd_base = rd_seen;
    for (int i = 0; i < 20; i++) runCycle(0, 0, 100, 100, 100);
    @(negedge clk);
    #1;
    checkOutput("read_burst_count", 32'(rd_seen - rd_base), 10);
    rd_left = 1000000;

    // Both sides saturating: quota-limited alternation
    for (int i = 0; i < 60; i++) runCycle(0, 100, 100, 100, 100);
    // Write-data FIFO back-pressure
    for (int i = 0; i < 200; i++) runCycle(0, 80, 80, 100, 30);
    // MIG command back-pressure
    for (int i = 0; i < 200; i++) runCycle(0, 60, 80, 50, 100);
    // Fully random mix
    for (int i = 0; i < 300; i++) runCycle(0, $urandom_range(100), $urandom_range(100), 70, 70);

    // Reset while the write side owns the port with a command pending
    reached = 0;
    for (int i = 0; i < 60 && !reached; i++) begin
      runCycle(0, 100, 0, 100, 100);
      if (m_owner == 1 && m_silence == 0) reached = 1;
    end
    checkOutput("reach_write_grant", 32'(reached), 1);
    runCycle(1, 100, 0, 100, 100);
    runCycle(1, 100, 50, 100, 100);
    checkResetOutputs();

    // Traffic after reset, then drain
    for (int i = 0; i < 150; i++) runCycle(0, 50, 50, 80, 80);
    for (int i = 0; i < 40; i++) runCycle(0, 0, 0, 100, 100);
    @(negedge clk);
    #1;
    checkOutput("queue_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
